rv32i_lsu: RTL and testbench
============================

RV32I_LSU -- requirements
Module: RV32I_lsu

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data bus width in bits (legal values 32 and 64).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning byte-address width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning maximum cycles to wait for bus_ack (minimum 1).
REQ-004 clk  in  1  single clock, all logic rising-edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 req_valid  in  1  core presents an access.
REQ-007 req_ready  out  1  LSU can accept an access.
REQ-008 req_we  in  1  1 = store, 0 = load.
REQ-009 req_size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = double (legal only when XLEN=64).
REQ-010 req_unsigned  in  1  zero-extend load when 1, sign-extend when 0.
REQ-011 req_addr  in  ADDR_WIDTH  byte address.
REQ-012 req_wdata  in  XLEN  store data, right-aligned.
REQ-013 rsp_valid  out  1  one-cycle response strobe.
REQ-014 rsp_rdata  out  XLEN  extended load data; 0 for stores and errors.
REQ-015 rsp_error  out  2  error code: 0 = none, 1 = misaligned, 2 = illegal size, 3 = bus timeout.
REQ-016 bus_addr  out  ADDR_WIDTH  access address, aligned to XLEN/8.
REQ-017 bus_wrdata  out  XLEN  lane-steered store data.
REQ-018 bus_byte_en  out  XLEN/8  active byte lanes.
REQ-019 bus_wren, bus_rden  out  1 each  write and read strobes; never both high.
REQ-020 bus_ack  in  1  slave completion; bus_rddata is valid in the same cycle.
REQ-021 bus_rddata  in  XLEN  read data.

Function
REQ-022 The state machine SHALL have three states, IDLE, ACCESS and RESP; req_ready SHALL be 1 only in IDLE.
REQ-023 An access SHALL be accepted on a clock edge where the state is IDLE and req_valid is 1; all request fields SHALL be registered on that edge.
REQ-024 A misaligned access (address not a multiple of the access size in bytes) or an illegal size SHALL go IDLE->RESP with the error set and no bus strobe.
REQ-025 A legal access SHALL go IDLE->ACCESS.
REQ-026 In ACCESS:
- bus_wren or bus_rden SHALL be held high until bus_ack is sampled high.
- bus_addr, bus_wrdata and bus_byte_en SHALL stay stable.
- On bus_ack the state SHALL go to RESP.
REQ-027 Byte lanes:
- bus_byte_en SHALL be the size mask shifted left by the low address bits (offset).
- bus_wrdata SHALL be req_wdata shifted left by 8*offset.
REQ-028 Load data:
- The value SHALL be extracted from bus_rddata at 8*offset.
- It SHALL be extended to XLEN per req_unsigned.
- It SHALL be captured on the bus_ack cycle.
REQ-029 A wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without ack; reaching TIMEOUT_CYCLES SHALL drop the strobe, set error 3 and go to RESP.
REQ-030 If bus_ack arrives in the same cycle the counter reaches its limit, the ack SHALL win (no error).
REQ-031 RESP SHALL last exactly one cycle with rsp_valid=1, then return to IDLE; new acceptance is earliest the cycle after RESP.
REQ-032 Latency: accept at edge N; strobe high during cycle N+1; with ack in cycle N+1+k, rsp_valid is high during cycle N+2+k. Error path: rsp_valid is high during cycle N+1.
REQ-033 bus_ack outside ACCESS SHALL be ignored.

Reset
REQ-034 Asserting rst SHALL immediately force state IDLE, counter 0, and all outputs 0 except req_ready, which SHALL be 1 after reset; this includes reset in the middle of ACCESS (strobe drops without waiting for ack).
REQ-035 No response SHALL be emitted for an access interrupted by reset.

Structure
REQ-036 The access-size enum, the error-code enum and the state enum SHALL live in be_pkg; the defaults SHALL come from RV32I_defines.sv.
REQ-037 Lane steering and extension SHALL be one sub-module, RV32I_lsu_lane_align, which is purely combinational and parametrised by XLEN.

Verification
REQ-038 LW, address 0x100, ack after 2 wait cycles, rddata 0xDEADBEEF -> rden held 3 cycles; rsp_rdata 0xDEADBEEF; error 0.
REQ-039 LB signed, address 0x103, rddata 0x80FF_FFFF -> byte_en 4'b1000; rsp_rdata 0xFFFFFF80.
REQ-040 SH, address 0x102, wdata 0x0000ABCD -> bus_wrdata 0xABCD0000, byte_en 4'b1100, bus_addr 0x100.
REQ-041 LW at address 0x101 -> no strobe; rsp_error 1 one cycle after accept.
REQ-042 TIMEOUT_CYCLES=4, ack never -> strobe high 4 cycles, then rsp_error 3; a second case with ack on the 4th wait cycle -> error 0.
REQ-043 XLEN=64, LD at 0x8 and LHU at 0xE with rddata 0x8001_0000_0000_0000 -> LHU rsp_rdata 0x8001; rst mid-ACCESS -> strobe low asynchronously and no rsp_valid.

Source files
------------

// File: rtl/be_pkg.sv
// Shared types and defaults for the RV32I load/store unit: access sizes,
// response error codes, FSM states and the request legality check.
package be_pkg;

  localparam int unsigned LSU_XLEN_DEFAULT       = 32;
  localparam int unsigned LSU_ADDR_WIDTH_DEFAULT = 32;
  localparam int unsigned LSU_TIMEOUT_DEFAULT    = 16;

  typedef enum logic [1:0] {
    SZ_BYTE   = 2'd0,
    SZ_HALF   = 2'd1,
    SZ_WORD   = 2'd2,
    SZ_DOUBLE = 2'd3
  } lsu_size_e;

  typedef enum logic [1:0] {
    ERR_NONE         = 2'd0,
    ERR_MISALIGNED   = 2'd1,
    ERR_ILLEGAL_SIZE = 2'd2,
    ERR_TIMEOUT      = 2'd3
  } lsu_err_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

  // Illegal size takes precedence over misalignment.
  function automatic lsu_err_e check_access(input lsu_size_e size,
                                            input logic [2:0] addr_lo,
                                            input logic       is_rv64);
    logic misaligned;
    misaligned = 1'b0;
    case (size)
      SZ_HALF:   misaligned = addr_lo[0];
      SZ_WORD:   misaligned = |addr_lo[1:0];
      SZ_DOUBLE: misaligned = |addr_lo;
      default:   misaligned = 1'b0;
    endcase
    if (size == SZ_DOUBLE && !is_rv64) return ERR_ILLEGAL_SIZE;
    if (misaligned) return ERR_MISALIGNED;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/rv32i_lsu_lane_align.sv
// Combinational byte-lane steering for stores and extraction/extension for loads.
module rv32i_lsu_lane_align
  import be_pkg::*;
#(
  parameter int unsigned XLEN = LSU_XLEN_DEFAULT,
  localparam int unsigned NB   = XLEN / 8,
  localparam int unsigned OFFW = $clog2(NB)
) (
  input  lsu_size_e         size_i,
  input  logic              uns_i,
  input  logic [OFFW-1:0]   offset_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [XLEN-1:0]   rddata_i,
  output logic [NB-1:0]     byte_en_o,
  output logic [XLEN-1:0]   wrdata_o,
  output logic [XLEN-1:0]   rdata_o
);

  logic [7:0]      mask8;
  logic [XLEN-1:0] keep;
  logic [XLEN-1:0] sh;
  logic            sgn;

  always_comb begin
    sh    = rddata_i >> {offset_i, 3'b000};
    mask8 = 8'h01;
    keep  = XLEN'(8'hFF);
    sgn   = sh[7];
    case (size_i)
      SZ_HALF: begin
        mask8 = 8'h03;
        keep  = XLEN'(16'hFFFF);
        sgn   = sh[15];
      end
      SZ_WORD: begin
        mask8 = 8'h0F;
        keep  = XLEN'(32'hFFFF_FFFF);
        sgn   = sh[31];
      end
      SZ_DOUBLE: begin
        mask8 = 8'hFF;
        keep  = '1;
        sgn   = sh[XLEN-1];
      end
      default: ;
    endcase
    byte_en_o = mask8[NB-1:0] << offset_i;
    wrdata_o  = wdata_i << {offset_i, 3'b000};
    // Bits above the access width are filled with the sign (or zero).
    rdata_o   = (sh & keep) | (~keep & {XLEN{sgn & ~uns_i}});
  end

endmodule

// File: rtl/rv32i_lsu.sv
// Load/store unit: accepts one core access at a time, runs a single bus
// transaction with timeout, and returns a one-cycle response.
module rv32i_lsu
  import be_pkg::*;
#(
  parameter int unsigned XLEN           = LSU_XLEN_DEFAULT,
  parameter int unsigned ADDR_WIDTH     = LSU_ADDR_WIDTH_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [XLEN-1:0]       req_wdata,
  output logic                  rsp_valid,
  output logic [XLEN-1:0]       rsp_rdata,
  output logic [1:0]            rsp_error,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [XLEN-1:0]       bus_wrdata,
  output logic [XLEN/8-1:0]     bus_byte_en,
  output logic                  bus_wren,
  output logic                  bus_rden,
  input  logic                  bus_ack,
  input  logic [XLEN-1:0]       bus_rddata
);

  localparam int unsigned NB   = XLEN / 8;
  localparam int unsigned OFFW = $clog2(NB);
  localparam int unsigned CW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  lsu_state_e            state_q;
  logic                  we_q;
  lsu_size_e             size_q;
  logic                  uns_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [XLEN-1:0]       wdata_q;
  logic [CW-1:0]         cnt_q;
  logic                  wren_q;
  logic                  rden_q;
  logic [XLEN-1:0]       rdata_q;
  lsu_err_e              err_q;

  lsu_err_e        req_err;
  logic [NB-1:0]   lane_be;
  logic [XLEN-1:0] lane_wrdata;
  logic [XLEN-1:0] lane_rdata;
  logic            in_access;

  assign req_err   = check_access(lsu_size_e'(req_size), req_addr[2:0], XLEN == 64);
  assign in_access = (state_q == ST_ACCESS);

  rv32i_lsu_lane_align #(.XLEN(XLEN)) u_lane_align (
    .size_i    (size_q),
    .uns_i     (uns_q),
    .offset_i  (addr_q[OFFW-1:0]),
    .wdata_i   (wdata_q),
    .rddata_i  (bus_rddata),
    .byte_en_o (lane_be),
    .wrdata_o  (lane_wrdata),
    .rdata_o   (lane_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      wren_q  <= 1'b0;
      rden_q  <= 1'b0;
      rdata_q <= '0;
      err_q   <= ERR_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            size_q  <= lsu_size_e'(req_size);
            uns_q   <= req_unsigned;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= req_err;
            if (req_err != ERR_NONE) begin
              state_q <= ST_RESP;
            end else begin
              wren_q  <= req_we;
              rden_q  <= ~req_we;
              state_q <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          // An ack on the final wait cycle still completes without error.
          if (bus_ack) begin
            wren_q  <= 1'b0;
            rden_q  <= 1'b0;
            if (!we_q) rdata_q <= lane_rdata;
            state_q <= ST_RESP;
          end else if (cnt_q == CNT_LAST) begin
            wren_q  <= 1'b0;
            rden_q  <= 1'b0;
            err_q   <= ERR_TIMEOUT;
            state_q <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_rdata   = rsp_valid ? rdata_q : '0;
  assign rsp_error   = rsp_valid ? err_q : ERR_NONE;
  assign bus_wren    = wren_q;
  assign bus_rden    = rden_q;
  assign bus_addr    = in_access ? (addr_q & ~ADDR_WIDTH'(NB - 1)) : '0;
  assign bus_wrdata  = in_access ? lane_wrdata : '0;
  assign bus_byte_en = in_access ? lane_be : '0;

endmodule

// File: tb/tb_rv32i_lsu.sv
// Directed bench for rv32i_lsu: a 32-bit and a 64-bit instance, both with a
// 4-cycle timeout, checked every cycle against an arithmetic model.
module tb_rv32i_lsu;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel;
  logic        req_valid, req_we, req_uns, bus_ack;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [63:0] req_wdata, bus_rddata;

  logic        r32_ready, r32_valid, r32_wren, r32_rden;
  logic [31:0] r32_rdata, r32_addr, r32_wd;
  logic [1:0]  r32_err;
  logic [3:0]  r32_be;
  logic        r64_ready, r64_valid, r64_wren, r64_rden;
  logic [63:0] r64_rdata, r64_wd;
  logic [31:0] r64_addr;
  logic [1:0]  r64_err;
  logic [7:0]  r64_be;

  always #5 clk = ~clk;

  rv32i_lsu #(.XLEN(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) u_dut32 (
    .clk(clk), .rst(rst), .req_valid(req_valid & ~sel), .req_ready(r32_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_uns),
    .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
    .rsp_valid(r32_valid), .rsp_rdata(r32_rdata), .rsp_error(r32_err),
    .bus_addr(r32_addr), .bus_wrdata(r32_wd), .bus_byte_en(r32_be),
    .bus_wren(r32_wren), .bus_rden(r32_rden), .bus_ack(bus_ack),
    .bus_rddata(bus_rddata[31:0])
  );

  rv32i_lsu #(.XLEN(64), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) u_dut64 (
    .clk(clk), .rst(rst), .req_valid(req_valid & sel), .req_ready(r64_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_uns),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(r64_valid), .rsp_rdata(r64_rdata), .rsp_error(r64_err),
    .bus_addr(r64_addr), .bus_wrdata(r64_wd), .bus_byte_en(r64_be),
    .bus_wren(r64_wren), .bus_rden(r64_rden), .bus_ack(bus_ack),
    .bus_rddata(bus_rddata)
  );

  logic        o_ready, o_valid, o_wren, o_rden;
  logic [63:0] o_rdata, o_wd;
  logic [31:0] o_addr;
  logic [1:0]  o_err;
  logic [7:0]  o_be;

  always_comb begin
    o_ready = sel ? r64_ready : r32_ready;
    o_valid = sel ? r64_valid : r32_valid;
    o_wren  = sel ? r64_wren  : r32_wren;
    o_rden  = sel ? r64_rden  : r32_rden;
    o_rdata = sel ? r64_rdata : {32'd0, r32_rdata};
    o_wd    = sel ? r64_wd    : {32'd0, r32_wd};
    o_addr  = sel ? r64_addr  : r32_addr;
    o_err   = sel ? r64_err   : r32_err;
    o_be    = sel ? r64_be    : {4'd0, r32_be};
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [1:0] m_err(input int xl, input logic [1:0] sz, input logic [31:0] a);
    int nb;
    nb = 1 << sz;
    if (sz == 2'd3 && xl == 32) return 2'd2;
    if ((a % nb) != 0) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [63:0] m_load(input int xl, input logic [1:0] sz, input logic u,
                                         input int off, input logic [63:0] rd);
    int nb;
    logic [63:0] m, v;
    nb = 1 << sz;
    m  = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
    v  = (rd >> (8 * off)) & m;
    if (!u && (((v >> (8 * nb - 1)) & 64'd1) != 0)) v = v | ~m;
    if (xl == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    return v;
  endfunction

  function automatic logic [7:0] m_be(input int xl, input logic [1:0] sz, input int off);
    int nb;
    int v;
    nb = 1 << sz;
    v  = ((1 << nb) - 1) << off;
    return 8'(v & ((1 << (xl / 8)) - 1));
  endfunction

  function automatic logic [63:0] m_wd(input int xl, input logic [63:0] wd, input int off);
    logic [63:0] v;
    v = wd << (8 * off);
    if (xl == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    return v;
  endfunction

  // ---------------- per-cycle expectations and compare ----------------
  logic        chk_en = 1'b0;
  logic        e_ready, e_valid, e_wren, e_rden;
  logic [63:0] e_rdata, e_wd;
  logic [31:0] e_addr;
  logic [1:0]  e_err;
  logic [7:0]  e_be;

  int          strobe_cnt = 0;
  logic [63:0] last_rdata, last_wd;
  logic [31:0] last_addr;
  logic [7:0]  last_be;
  logic [1:0]  last_err;

  always @(negedge clk) begin
    if (o_rden || o_wren) begin
      strobe_cnt++;
      last_be   = o_be;
      last_addr = o_addr;
      last_wd   = o_wd;
    end
    if (o_valid) begin
      last_rdata = o_rdata;
      last_err   = o_err;
    end
    if (chk_en) begin
      chk("req_ready", {63'd0, o_ready}, {63'd0, e_ready});
      chk("bus_rden",  {63'd0, o_rden},  {63'd0, e_rden});
      chk("bus_wren",  {63'd0, o_wren},  {63'd0, e_wren});
      chk("rsp_valid", {63'd0, o_valid}, {63'd0, e_valid});
      if (e_rden || e_wren) begin
        chk("bus_addr",    {32'd0, o_addr}, {32'd0, e_addr});
        chk("bus_byte_en", {56'd0, o_be},   {56'd0, e_be});
        chk("bus_wrdata",  o_wd, e_wd);
      end
      if (e_valid) begin
        chk("rsp_error", {62'd0, o_err}, {62'd0, e_err});
        chk("rsp_rdata", o_rdata, e_rdata);
      end
    end
  end

  task automatic set_idle();
    e_ready = 1'b1;
    e_rden  = 1'b0;
    e_wren  = 1'b0;
    e_valid = 1'b0;
  endtask

  task automatic idle(input int n, input logic ackv);
    for (int i = 0; i < n; i++) begin
      set_idle();
      bus_ack = ackv;
      @(posedge clk); #1;
    end
    bus_ack = 1'b0;
  endtask

  // One access; ackd is the wait-cycle index of the ack (>= TO means never).
  task automatic acc(input logic s, input logic we, input logic [1:0] sz, input logic u,
                     input logic [31:0] a, input logic [63:0] wd, input logic [63:0] rd,
                     input int ackd);
    int xl, off, w;
    logic [1:0] er;
    logic to, done;
    xl  = s ? 64 : 32;
    off = int'(a % (xl / 8));
    er  = m_err(xl, sz, a);
    sel = s;
    strobe_cnt = 0;
    req_valid = 1'b1; req_we = we; req_size = sz; req_uns = u;
    req_addr = a; req_wdata = wd;
    set_idle();
    @(posedge clk); #1;
    // Scramble request fields: the DUT must work from its registered copy.
    req_valid = 1'b0; req_we = ~we; req_size = ~sz; req_uns = ~u;
    req_addr = ~a; req_wdata = ~wd;
    if (er != 2'd0) begin
      e_ready = 1'b0; e_rden = 1'b0; e_wren = 1'b0;
      e_valid = 1'b1; e_err = er; e_rdata = 64'd0;
      @(posedge clk); #1;
    end else begin
      e_ready = 1'b0; e_rden = ~we; e_wren = we; e_valid = 1'b0;
      e_addr = a - 32'(off); e_be = m_be(xl, sz, off); e_wd = m_wd(xl, wd, off);
      to = 1'b1; done = 1'b0; w = 0;
      while (w < TO && !done) begin
        bus_ack = (w == ackd); bus_rddata = rd;
        @(posedge clk); #1;
        if (w == ackd) begin to = 1'b0; done = 1'b1; end
        w++;
      end
      bus_ack = 1'b0; bus_rddata = ~rd;
      e_rden = 1'b0; e_wren = 1'b0; e_valid = 1'b1;
      e_err   = to ? 2'd3 : 2'd0;
      e_rdata = (to || we) ? 64'd0 : m_load(xl, sz, u, off, rd);
      @(posedge clk); #1;
    end
    set_idle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_uns = 1'b0; bus_ack = 1'b0;
    req_size = 2'd0; req_addr = '0; req_wdata = '0; bus_rddata = '0;
    set_idle();
    @(negedge clk);
    chk("rst32_ready", {63'd0, r32_ready}, 64'd1);
    chk("rst32_strobes", {62'd0, r32_rden, r32_wren}, 64'd0);
    chk("rst32_rsp", {29'd0, r32_valid, r32_err, r32_rdata}, 64'd0);
    chk("rst32_bus", {r32_addr, r32_wd}, 64'd0);
    chk("rst32_be", {60'd0, r32_be}, 64'd0);
    chk("rst64_ready", {63'd0, r64_ready}, 64'd1);
    chk("rst64_strobes", {61'd0, r64_valid, r64_rden, r64_wren}, 64'd0);
    chk("rst64_rsp", r64_rdata | {62'd0, r64_err}, 64'd0);
    chk("rst64_bus", r64_wd | {32'd0, r64_addr} | {56'd0, r64_be}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;
    idle(2, 1'b1);

    acc(0, 0, 2'd2, 0, 32'h100, 64'd0, 64'hDEADBEEF, 2);
    chk("lw_strobe_cycles", 64'(strobe_cnt), 64'd3);
    chk("lw_rdata", last_rdata, 64'hDEADBEEF);
    chk("lw_err", {62'd0, last_err}, 64'd0);

    acc(0, 0, 2'd0, 0, 32'h103, 64'd0, 64'h80FF_FFFF, 0);
    chk("lb_be", {56'd0, last_be}, 64'h8);
    chk("lb_rdata", last_rdata, 64'hFFFF_FF80);

    acc(0, 1, 2'd1, 0, 32'h102, 64'h0000_ABCD, 64'd0, 1);
    chk("sh_wrdata", last_wd, 64'hABCD_0000);
    chk("sh_be", {56'd0, last_be}, 64'hC);
    chk("sh_addr", {32'd0, last_addr}, 64'h100);
    chk("sh_rdata", last_rdata, 64'd0);

    acc(0, 0, 2'd2, 0, 32'h101, 64'd0, 64'd0, 0);
    chk("mis_strobe_cycles", 64'(strobe_cnt), 64'd0);
    chk("mis_err", {62'd0, last_err}, 64'd1);

    acc(0, 0, 2'd2, 0, 32'h200, 64'd0, 64'h5555_5555, 99);
    chk("to_strobe_cycles", 64'(strobe_cnt), 64'd4);
    chk("to_err", {62'd0, last_err}, 64'd3);

    acc(0, 0, 2'd2, 0, 32'h204, 64'd0, 64'h1234_5678, 3);
    chk("lastack_strobe_cycles", 64'(strobe_cnt), 64'd4);
    chk("lastack_err", {62'd0, last_err}, 64'd0);
    chk("lastack_rdata", last_rdata, 64'h1234_5678);

    acc(0, 0, 2'd3, 0, 32'h0, 64'd0, 64'd0, 0);
    chk("illegal_err", {62'd0, last_err}, 64'd2);

    acc(0, 0, 2'd1, 0, 32'h2, 64'd0, 64'hBEEF_1234, 0);
    chk("lh_rdata", last_rdata, 64'hFFFF_BEEF);
    acc(0, 0, 2'd1, 1, 32'h2, 64'd0, 64'hBEEF_1234, 1);
    chk("lhu_rdata", last_rdata, 64'h0000_BEEF);
    acc(0, 0, 2'd0, 1, 32'h1, 64'd0, 64'h0000_8000, 0);
    chk("lbu_rdata", last_rdata, 64'h80);
    acc(0, 1, 2'd0, 0, 32'h1, 64'hA5, 64'd0, 2);
    chk("sb_wrdata", last_wd, 64'hA500);
    chk("sb_be", {56'd0, last_be}, 64'h2);
    acc(0, 0, 2'd1, 0, 32'h3, 64'd0, 64'd0, 0);
    idle(3, 1'b1);

    acc(1, 0, 2'd3, 0, 32'h8, 64'd0, 64'h8001_0000_0000_0000, 0);
    chk("ld_rdata", last_rdata, 64'h8001_0000_0000_0000);
    chk("ld_be", {56'd0, last_be}, 64'hFF);
    acc(1, 0, 2'd1, 1, 32'hE, 64'd0, 64'h8001_0000_0000_0000, 1);
    chk("lhu64_rdata", last_rdata, 64'h8001);
    chk("lhu64_be", {56'd0, last_be}, 64'hC0);
    chk("lhu64_addr", {32'd0, last_addr}, 64'h8);
    acc(1, 0, 2'd2, 0, 32'hC, 64'd0, 64'h8000_0000_0000_0000, 2);
    chk("lw64_rdata", last_rdata, 64'hFFFF_FFFF_8000_0000);
    acc(1, 1, 2'd3, 0, 32'h10, 64'h1122_3344_5566_7788, 64'd0, 0);
    chk("sd_wrdata", last_wd, 64'h1122_3344_5566_7788);
    acc(1, 0, 2'd3, 0, 32'h4, 64'd0, 64'd0, 0);
    chk("ld_mis_err", {62'd0, last_err}, 64'd1);
    acc(1, 0, 2'd2, 0, 32'h6, 64'd0, 64'd0, 0);
    acc(1, 0, 2'd0, 0, 32'h7, 64'd0, 64'h7F00_0000_0000_0000, 99);

    // Reset in the middle of a 64-bit access.
    chk_en = 1'b0;
    sel = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_size = 2'd3; req_uns = 1'b0;
    req_addr = 32'h8;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_pre_rden", {63'd0, r64_rden}, 64'd1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rst_async_rden", {63'd0, r64_rden}, 64'd0);
    chk("rst_async_addr", {32'd0, r64_addr}, 64'd0);
    chk("rst_async_ready", {63'd0, r64_ready}, 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    bus_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_no_rsp", {62'd0, r64_valid, r64_rden}, 64'd0);
      chk("rst_ready", {63'd0, r64_ready}, 64'd1);
    end
    bus_ack = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
